// File: rtl/credit_fifo_if.sv
// credit_fifo_if: flit write port, allocator grants and credit return.
// err_out exists only when CREDIT_FIFO_ERR_EN is defined.
interface credit_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] rx;
  logic                  valid_in;
  logic                  read_en_N;
  logic                  read_en_E;
  logic                  read_en_W;
  logic                  read_en_S;
  logic                  read_en_L;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty_out;
  logic                  credit_out;
`ifdef CREDIT_FIFO_ERR_EN
  logic                  err_out;
`endif

  modport master (
    output rx, valid_in,
    output read_en_N, read_en_E, read_en_W,
    output read_en_S, read_en_L,
    input  data_out, empty_out, credit_out
`ifdef CREDIT_FIFO_ERR_EN
    , input err_out
`endif
  );

  modport slave (
    input  rx, valid_in,
    input  read_en_N, read_en_E, read_en_W,
    input  read_en_S, read_en_L,
    output data_out, empty_out, credit_out
`ifdef CREDIT_FIFO_ERR_EN
    , output err_out
`endif
  );
endinterface

// File: rtl/credit_fifo.sv
// credit_fifo: 4-slot FWFT input buffer returning one credit per read.
// Define CREDIT_FIFO_ERR_EN to add the sticky err_out protocol monitor.
module credit_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic          clk,
  input logic          reset,
  credit_fifo_if.slave bus
);
  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       credit_q, credit_d;
  logic [4:0] read_en;
  logic       read_req;
  logic       full, empty;
  logic       wr_en, rd_en;

  assign read_en = {bus.read_en_L, bus.read_en_S,
                    bus.read_en_W, bus.read_en_E,
                    bus.read_en_N};
  assign read_req = |read_en;

  // Full/empty come from registered count only, so a
  // same-cycle read never frees room for a write.
  assign full  = count_q == FULL_CNT;
  assign empty = count_q == 3'd0;
  assign wr_en = bus.valid_in & ~full;
  assign rd_en = read_req & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + 2'(wr_en);
    rd_ptr_d = rd_ptr_q + 2'(rd_en);
    credit_d = rd_en;
    count_d  = count_q;
    unique case (1'b1)
      wr_en & ~rd_en: count_d = count_q + 3'd1;
      rd_en & ~wr_en: count_d = count_q - 3'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.rx;
  end

  assign bus.data_out   = mem_q[rd_ptr_q];
  assign bus.empty_out  = empty;
  assign bus.credit_out = credit_q;

`ifdef CREDIT_FIFO_ERR_EN
  logic err_q, err_d;
  logic multi;

  always_comb begin
    multi = |(read_en & (read_en - 5'd1));
    err_d = err_q
          | (bus.valid_in & full)
          | (read_req & empty)
          | multi;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err_out = err_q;
`endif
endmodule

// File: doc/credit_fifo.md
CREDIT_FIFO -- requirements
Module: credit_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 Parameter DEPTH, fixed at 4, number of flit slots; pointers are 2 bits and the occupancy count is 3 bits.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  DATA_WIDTH  incoming flit from the upstream router/link.
REQ-006 valid_in  input  1  rx holds a flit to be written this cycle.
REQ-007 read_en_N, read_en_E, read_en_W, read_en_S, read_en_L  input  1 each  allocator grant for this input port towards each output; at most one high per cycle.
REQ-008 data_out  output  DATA_WIDTH  head flit (first-word-fall-through).
REQ-009 empty_out  output  1  FIFO holds no flit; consumed by the allocator.
REQ-010 credit_out  output  1  one-cycle pulse returning one credit upstream.
REQ-011 err_out  output  1  sticky protocol error; present only with CREDIT_FIFO_ERR_EN.

Function
REQ-012 read_req SHALL be the OR of the five read_en inputs.
REQ-013 Write SHALL occur at the clock edge when valid_in=1 and count<4: mem[wr_ptr]<=rx and wr_ptr+1 (mod 4).
REQ-014 Read SHALL occur at the clock edge when read_req=1 and count>0: rd_ptr+1 (mod 4).
REQ-015 count SHALL update +1 on write only, -1 on read only, and stay unchanged on simultaneous read and write.
REQ-016 Full and empty decisions SHALL use registered state only; a write when count=4 SHALL be dropped even if a read occurs in the same cycle.
REQ-017 A read request when count=0 SHALL be ignored even if a write occurs in the same cycle; the written flit becomes visible the next cycle.
REQ-018 data_out SHALL combinationally equal mem[rd_ptr]; its value is don't-care while empty_out=1.
REQ-019 empty_out SHALL be 1 exactly when count=0, combinationally from state, with zero-cycle latency.
REQ-020 credit_out SHALL be registered and equal 1 in the cycle following each successful read, and 0 otherwise.
REQ-021 Back-to-back reads SHALL give back-to-back credit_out pulses, with no merging or loss.
REQ-022 Pointer wrap-around from 3 to 0 SHALL be seamless; ordering SHALL be strict FIFO.
REQ-023 Write-to-read latency SHALL be one cycle: a flit written at edge k is readable and drives data_out after edge k.

Reset
REQ-024 While reset=0: rd_ptr=0, wr_ptr=0, count=0, credit_out=0, err_out=0, empty_out=1.
REQ-025 Reset SHALL take effect asynchronously mid-operation and discard stored flits; memory contents need not be cleared.
REQ-026 No credit_out pulse SHALL be generated by reset assertion or deassertion.

Configuration
REQ-027 Macro CREDIT_FIFO_ERR_EN, when defined, SHALL add err_out, set sticky until reset. It is set at the edge after any of the following:
- write with count=4 (overflow);
- read_req with count=0 (underflow);
- more than one read_en high.
REQ-028 Without CREDIT_FIFO_ERR_EN, err_out and its logic SHALL be absent; dropped writes and ignored reads still behave per REQ-016/017.

Verification
REQ-029 Reset, then write 0xA1, 0xB2, 0xC3 on consecutive cycles with no reads -> empty_out falls after the first edge, count=3, data_out=0xA1.
REQ-030 From the REQ-029 state, read_en_E=1 for 3 cycles -> data_out sequence is 0xA1, 0xB2, 0xC3; credit_out is high 3 consecutive cycles, each lagging its read by 1; empty_out=1 after the third read.
REQ-031 Fill 4 flits, then write 0xFF with read_en_L=1 in the same cycle -> 0xFF dropped, count=3; with ERR_EN, err_out=1 next cycle.
REQ-032 Empty FIFO, valid_in=1 with rx=0x55 and read_en_N=1 in the same cycle -> no read and no credit; next cycle data_out=0x55, empty_out=0.
REQ-033 Stream 10 flits with simultaneous write+read every cycle after the first -> pointers wrap, order is preserved, count stays 1, 9 credit pulses.
REQ-034 Assert reset mid-stream with count=2 -> empty_out=1 immediately, credit_out=0, err_out=0, and no credit pulse after release.
